// File: rtl/spi_xfer_ctrl.sv
// Mode-0 SPI master: one host command per transfer, response returned on a valid/ready channel.
// Optional macro SPI_XFER_CTRL_LSB_FIRST_EN adds cmd_lsb for LSB-first transfers.
module spi_xfer_ctrl #(
    parameter int NUM_SS = 8,
    parameter int DATA_W = 64,
    parameter int DIV_W  = 16,
    localparam int SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1,
    localparam int LEN_W = $clog2(DATA_W),
    localparam int BL_W  = LEN_W + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SS_W-1:0]   cmd_ss,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DIV_W-1:0]  cmd_div,
    input  logic [DATA_W-1:0] cmd_data,
`ifdef SPI_XFER_CTRL_LSB_FIRST_EN
    input  logic              cmd_lsb,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              sck,
    output logic [NUM_SS-1:0] ss_n,
    output logic              mosi,
    input  logic              miso
);

    typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, HOLD, RESP} state_t;

    state_t             state;
    state_t             state_next;
    logic [DIV_W-1:0]   cnt;
    logic [DIV_W-1:0]   div_q;
    logic [BL_W-1:0]    bits_left;
    logic [LEN_W-1:0]   idx;
    logic [LEN_W-1:0]   idx_next;
    logic [LEN_W-1:0]   first_idx;
    logic [DATA_W-1:0]  tx_data;
    logic [DATA_W-1:0]  rx;
    logic               lsb_sel;
    logic               lsb_q;
    logic               phase_end;
    logic               last_bit;
    logic               accept;

`ifdef SPI_XFER_CTRL_LSB_FIRST_EN
    assign lsb_sel = cmd_lsb;
`else
    assign lsb_sel = 1'b0;
`endif

    function automatic logic [NUM_SS-1:0] sel_mask(input logic [SS_W-1:0] ss);
        logic [NUM_SS-1:0] m;
        m = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (int'(ss) == i) m[i] = 1'b0;
        end
        return m;
    endfunction

    assign cmd_ready = (state == IDLE);
    assign accept    = (state == IDLE) && cmd_valid;
    assign phase_end = (cnt == '0);
    assign last_bit  = (bits_left == BL_W'(1));
    assign idx_next  = lsb_q ? idx + LEN_W'(1) : idx - LEN_W'(1);
    assign first_idx = lsb_sel ? '0 : cmd_len;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (cmd_valid) state_next = SETUP;
            SETUP:  if (phase_end) state_next = SCK_HI;
            SCK_HI: if (phase_end) state_next = last_bit ? HOLD : SCK_LO;
            SCK_LO: if (phase_end) state_next = SCK_HI;
            HOLD:   if (phase_end) state_next = RESP;
            RESP:   if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            div_q     <= '0;
            bits_left <= '0;
            sck       <= 1'b0;
            ss_n      <= '1;
            mosi      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state <= state_next;
            // Every phase reloads the divider, so each timed state lasts div+1 clocks.
            if (state_next != state) begin
                cnt <= (state == IDLE) ? cmd_div : div_q;
            end else if (cnt != '0) begin
                cnt <= cnt - DIV_W'(1);
            end
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        div_q     <= cmd_div;
                        bits_left <= {1'b0, cmd_len} + BL_W'(1);
                        ss_n      <= sel_mask(cmd_ss);
                        mosi      <= cmd_data[first_idx];
                    end
                end
                SETUP, SCK_LO: begin
                    if (phase_end) sck <= 1'b1;
                end
                SCK_HI: begin
                    if (phase_end) begin
                        sck       <= 1'b0;
                        bits_left <= bits_left - BL_W'(1);
                        if (!last_bit) mosi <= tx_data[idx_next];
                    end
                end
                HOLD: begin
                    if (phase_end) begin
                        ss_n      <= '1;
                        mosi      <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_data  <= rx;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // miso is captured on the same edge that raises sck.
    always_ff @(posedge clock) begin
        if (accept) begin
            tx_data <= cmd_data;
            rx      <= '0;
            lsb_q   <= lsb_sel;
            idx     <= first_idx;
        end else if ((state == SETUP || state == SCK_LO) && phase_end) begin
            if (lsb_q) rx[idx] <= miso;
            else       rx      <= {rx[DATA_W-2:0], miso};
        end else if (state == SCK_HI && phase_end) begin
            idx <= idx_next;
        end
    end

endmodule
